axi_lite_slave_regs: RTL and testbench

AXI-lite slave register bank attached to the DUT modport of the team's AXI-lite interface: it consumes the read-address, write-address, write-data and read-data channels and serves a bank of 32-bit control/status registers. The registers are exported in parallel to the rest of the design. There is no write-response channel and no byte strobes; every write is a full 32-bit word.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_if.sv | 37 +++
 rtl/axi_regbank.sv | 44 ++++
 rtl/axi_lite_slave_regs.sv | 130 +++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_pkg : shared AXI-lite constants and read-FSM state type     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package axi_lite_pkg;

    localparam int AXI_DATA_W   = 32;
    localparam int AXI_ADDR_LSB = 2;

    localparam logic [AXI_DATA_W-1:0] OOR_READ_VALUE = 32'h0;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_if : AXI-lite AW/W/AR/R channels (no write response)        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] write_addr;
    logic              write_addr_valid;
    logic              write_addr_ready;
    logic [DATA_W-1:0] write_data;
    logic              write_data_valid;
    logic              write_data_ready;
    logic [ADDR_W-1:0] read_addr;
    logic              read_addr_valid;
    logic              read_addr_ready;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              read_data_ready;

    modport master (
        output write_addr, write_addr_valid, input  write_addr_ready,
        output write_data, write_data_valid, input  write_data_ready,
        output read_addr,  read_addr_valid,  input  read_addr_ready,
        input  read_data,  read_data_valid,  output read_data_ready
    );

    modport slave (
        input  write_addr, write_addr_valid, output write_addr_ready,
        input  write_data, write_data_valid, output write_data_ready,
        input  read_addr,  read_addr_valid,  output read_addr_ready,
        output read_data,  read_data_valid,  input  read_data_ready
    );
endinterface
`default_nettype wire

// File: rtl/axi_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_regbank : register storage, one write port, one async read port  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module axi_regbank
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  wire logic                           clk,
    input  wire logic                           rstn,
    input  wire logic                           i_wr_en,
    input  wire logic [IDX_W-1:0]               i_wr_idx,
    input  wire logic [AXI_DATA_W-1:0]          i_wr_data,
    input  wire logic [IDX_W-1:0]               i_rd_idx,
    output logic      [AXI_DATA_W-1:0]          o_rd_data,
    output logic      [NUM_REGS*AXI_DATA_W-1:0] o_regs
);

    logic [AXI_DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Read sees the pre-edge contents, so a same-edge write returns the old value.
    assign o_rd_data = r_mem[i_rd_idx];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign o_regs[gi*AXI_DATA_W +: AXI_DATA_W] = r_mem[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_slave_regs : AXI-lite slave exporting a 32-bit register bank|
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rstn,
    axi_lite_if.slave                       bus,
    output logic [NUM_REGS*DATA_W-1:0]      regs_o
);

    localparam int c_idx_w = $clog2(NUM_REGS);
    localparam int c_idx_hi = AXI_ADDR_LSB + c_idx_w;

    logic              r_rst_done;
    logic              r_aw_held;
    logic              r_w_held;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [DATA_W-1:0] r_w_data;
    rd_state_t         r_rd_state;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_data_valid;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_unused;

    // Readies depend on flops only; rst_done holds them low for one cycle after reset.
    assign bus.write_addr_ready = r_rst_done & ~r_aw_held;
    assign bus.write_data_ready = r_rst_done & ~r_w_held;
    assign bus.read_addr_ready  = r_rst_done & (r_rd_state == R_IDLE);
    assign bus.read_data        = r_read_data;
    assign bus.read_data_valid  = r_read_data_valid;

    assign w_aw_hs  = bus.write_addr_valid & bus.write_addr_ready;
    assign w_w_hs   = bus.write_data_valid & bus.write_data_ready;
    assign w_ar_hs  = bus.read_addr_valid  & bus.read_addr_ready;
    assign w_commit = r_aw_held & r_w_held;

    assign w_wr_in_range = (r_aw_addr[ADDR_W-1:c_idx_hi] == '0);
    assign w_rd_in_range = (bus.read_addr[ADDR_W-1:c_idx_hi] == '0);

    assign w_unused = ^{r_aw_addr[AXI_ADDR_LSB-1:0], bus.read_addr[AXI_ADDR_LSB-1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= bus.write_addr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= bus.write_data;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_state        <= R_IDLE;
            r_read_data       <= '0;
            r_read_data_valid <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_read_data       <= w_rd_in_range ? w_rd_word : OOR_READ_VALUE;
                        r_read_data_valid <= 1'b1;
                        r_rd_state        <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.read_data_ready) begin
                        r_read_data_valid <= 1'b0;
                        r_rd_state        <= R_IDLE;
                    end
                end
                default: begin
                    r_read_data_valid <= 1'b0;
                    r_rd_state        <= R_IDLE;
                end
            endcase
        end
    end

    axi_regbank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (c_idx_w)
    ) u_regbank (
        .clk       (clk),
        .rstn      (rstn),
        .i_wr_en   (w_commit & w_wr_in_range),
        .i_wr_idx  (r_aw_addr[AXI_ADDR_LSB +: c_idx_w]),
        .i_wr_data (r_w_data),
        .i_rd_idx  (bus.read_addr[AXI_ADDR_LSB +: c_idx_w]),
        .o_rd_data (w_rd_word),
        .o_regs    (regs_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_lite_slave_regs : scoreboard bench for axi_lite_slave_regs    |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_axi_lite_slave_regs;

    localparam int NREG = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREG*32-1:0] regs_o;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_slave_regs #(
        .NUM_REGS (NREG),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .regs_o (regs_o)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    logic [31:0] model [NREG];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        logic [NREG*32-1:0] e;
        for (int i = 0; i < NREG; i++) e[i*32 +: 32] = model[i];
        checks++;
        if (regs_o !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, regs_o, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted read beat is checked against the oldest expectation.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (rstn === 1'b1 && bus.read_data_valid === 1'b1 && bus.read_data_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdata_unexpected actual=%h required=none", bus.read_data);
            end else begin
                e = sb.pop_front();
                chk("rdata", bus.read_data, e);
            end
        end
    end

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_now;
        bit w_now;
        int n = 0;
        bus.write_addr = a;
        bus.write_data = d;
        bus.write_addr_valid = 1'b1;
        bus.write_data_valid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = bus.write_addr_valid && bus.write_addr_ready;
            w_now  = bus.write_data_valid && bus.write_data_ready;
            tick;
            n++;
            if (aw_now) begin aw_done = 1'b1; bus.write_addr_valid = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; bus.write_data_valid = 1'b0; end
        end
        if (!(aw_done && w_done)) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout actual=no_handshake required=handshake addr=%h", a);
            bus.write_addr_valid = 1'b0;
            bus.write_data_valid = 1'b0;
        end
    endtask

    task automatic read_word(input logic [31:0] a, input logic [31:0] exp);
        int n = 0;
        sb.push_back(exp);
        bus.read_addr = a;
        bus.read_addr_valid = 1'b1;
        while (bus.read_addr_ready !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL rd_timeout actual=no_ready required=ready addr=%h", a);
        end
        tick;
        bus.read_addr_valid = 1'b0;
        chk1("rvalid_beat", bus.read_data_valid, 1'b1);
        tick;
        chk1("rvalid_one_cycle", bus.read_data_valid, 1'b0);
        chk1("arready_back", bus.read_addr_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        bus.write_addr = '0;
        bus.write_addr_valid = 1'b0;
        bus.write_data = '0;
        bus.write_data_valid = 1'b0;
        bus.read_addr = '0;
        bus.read_addr_valid = 1'b0;
        bus.read_data_ready = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        // Reset and release
        repeat (3) tick;
        chk1("rst_awready", bus.write_addr_ready, 1'b0);
        chk1("rst_wready", bus.write_data_ready, 1'b0);
        chk1("rst_arready", bus.read_addr_ready, 1'b0);
        chk1("rst_rvalid", bus.read_data_valid, 1'b0);
        chk("rst_rdata", bus.read_data, 32'h0);
        chk_regs("rst_regs");
        rstn = 1'b1;
        chk1("rel_awready_low", bus.write_addr_ready, 1'b0);
        chk1("rel_arready_low", bus.read_addr_ready, 1'b0);
        tick;
        chk1("rel_awready_high", bus.write_addr_ready, 1'b1);
        chk1("rel_wready_high", bus.write_data_ready, 1'b1);
        chk1("rel_arready_high", bus.read_addr_ready, 1'b1);

        // Same-cycle write then read
        write_word(32'h08, 32'hA5A5_0001);
        chk("wr_pre_commit", regs_o[95:64], 32'h0);
        tick;
        model[2] = 32'hA5A5_0001;
        chk_regs("wr_reg2");
        chk1("wr_awready_again", bus.write_addr_ready, 1'b1);
        read_word(32'h08, 32'hA5A5_0001);

        // W three cycles ahead of AW
        bus.write_data = 32'h1234_5678;
        bus.write_data_valid = 1'b1;
        tick;
        bus.write_data_valid = 1'b0;
        repeat (3) begin
            chk1("w_held_ready", bus.write_data_ready, 1'b0);
            chk("w_held_reg1", regs_o[63:32], 32'h0);
            tick;
        end
        bus.write_addr = 32'h04;
        bus.write_addr_valid = 1'b1;
        tick;
        bus.write_addr_valid = 1'b0;
        chk("skew_pre_commit", regs_o[63:32], 32'h0);
        tick;
        model[1] = 32'h1234_5678;
        chk_regs("skew_w_first");

        // AW three cycles ahead of W
        bus.write_addr = 32'h10;
        bus.write_addr_valid = 1'b1;
        tick;
        bus.write_addr_valid = 1'b0;
        repeat (3) begin
            chk1("aw_held_ready", bus.write_addr_ready, 1'b0);
            tick;
        end
        bus.write_data = 32'h1234_5678;
        bus.write_data_valid = 1'b1;
        tick;
        bus.write_data_valid = 1'b0;
        tick;
        model[4] = 32'h1234_5678;
        chk_regs("skew_aw_first");

        // Read backpressure
        write_word(32'h00, 32'h0000_C0DE);
        tick;
        model[0] = 32'h0000_C0DE;
        bus.read_data_ready = 1'b0;
        sb.push_back(32'h0000_C0DE);
        bus.read_addr = 32'h00;
        bus.read_addr_valid = 1'b1;
        tick;
        bus.read_addr_valid = 1'b0;
        repeat (5) begin
            chk1("bp_rvalid", bus.read_data_valid, 1'b1);
            chk("bp_rdata", bus.read_data, 32'h0000_C0DE);
            chk1("bp_arready", bus.read_addr_ready, 1'b0);
            tick;
        end
        bus.read_data_ready = 1'b1;
        tick;
        chk1("bp_done_rvalid", bus.read_data_valid, 1'b0);
        chk1("bp_done_arready", bus.read_addr_ready, 1'b1);

        // Out-of-range accesses and ignored low address bits
        write_word(32'h40, 32'hFFFF_FFFF);
        tick;
        tick;
        chk_regs("oor_write_dropped");
        read_word(32'h40, 32'h0);
        read_word(32'h0B, 32'hA5A5_0001);

        // AR handshake on the commit edge returns the old value
        write_word(32'h0C, 32'h1111_2222);
        tick;
        model[3] = 32'h1111_2222;
        bus.write_addr = 32'h0C;
        bus.write_data = 32'hDEAD_BEEF;
        bus.write_addr_valid = 1'b1;
        bus.write_data_valid = 1'b1;
        tick;
        bus.write_addr_valid = 1'b0;
        bus.write_data_valid = 1'b0;
        bus.read_addr = 32'h0C;
        bus.read_addr_valid = 1'b1;
        sb.push_back(32'h1111_2222);
        tick;
        bus.read_addr_valid = 1'b0;
        model[3] = 32'hDEAD_BEEF;
        chk_regs("coll_commit");
        chk1("coll_rvalid", bus.read_data_valid, 1'b1);
        tick;

        // Reset while a read beat is pending
        bus.read_data_ready = 1'b0;
        bus.read_addr = 32'h0C;
        bus.read_addr_valid = 1'b1;
        tick;
        bus.read_addr_valid = 1'b0;
        chk1("mid_rvalid", bus.read_data_valid, 1'b1);
        rstn = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        chk1("mid_rst_rvalid", bus.read_data_valid, 1'b0);
        chk_regs("mid_rst_regs");
        tick;
        rstn = 1'b1;
        bus.read_data_ready = 1'b1;
        tick;
        read_word(32'h0C, 32'h0);

        tick;
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
